// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI receiver: FSM encoding, pin idle levels
// and bit-counter sizing.
// Latency: n/a (definitions only). Backpressure: n/a.
package oled_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  // Levels the synchronizers hold in reset, matching an idle SPI bus.
  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b1;
  localparam logic SDIN_IDLE = 1'b0;
  localparam logic DC_IDLE   = 1'b0;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/oled_spi_rx_if.sv
// Received-byte stream: head byte, its DC flag, valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: master holds byte_dat/byte_dc stable while valid & !ready.
interface oled_spi_rx_if;
  import oled_pkg::*;

  logic [BYTE_W-1:0] byte_dat;
  logic              byte_dc;
  logic              valid;
  logic              ready;

  modport master (output byte_dat, output byte_dc, output valid, input ready);
  modport slave  (input byte_dat, input byte_dc, input valid, output ready);

endinterface

// File: rtl/oled_rx_fifo.sv
// Generic synchronous FIFO, valid/ready on both sides, full/empty flags.
// Latency: one cycle from write to out_vld.
// Backpressure: in_rdy is low only when full and the head is not being popped.
// Ports: in_vld/in_rdy/in_dat write side, out_vld/out_rdy/out_dat read side,
//        full/empty status. DEPTH must be a power of two.
module oled_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_vld = !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign in_rdy  = !full || out_rdy;
  assign wr_en   = in_vld && in_rdy;
  assign rd_en   = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_dat;
  end

endmodule

// File: rtl/oled_spi_rx.sv
// SPI slave receiver for an OLED controller bus: oversamples CS/SCLK/SDIN/DC,
// assembles MSB-first bytes and queues {DC, byte} for a consumer.
// Latency: VALID rises SYNC_STAGES+2 clk cycles after the 8th SCLK rising edge.
// Backpressure: none toward SPI; a byte arriving to a full, undrained FIFO is
//               dropped and sets sticky ovf.
// Ports: clk, rst_n (async active-low); cs, sclk, sdin, dc SPI pins; rx byte
//        stream (master modport); ovf, frame_err (1-cycle pulse), busy.
// Option: define OLED_RX_STATS_EN to add saturating cmd_cnt/data_cnt outputs.
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 sdin,
  input  logic                 dc,
  oled_spi_rx_if.master        rx,
  output logic                 ovf,
  output logic                 frame_err,
  output logic                 busy
`ifdef OLED_RX_STATS_EN
  ,
  output logic [15:0]          cmd_cnt,
  output logic [15:0]          data_cnt
`endif
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdin_sync, dc_sync;
  logic cs_s, sclk_s, sdin_s, dc_s;
  logic cs_prev, sclk_prev;
  logic cs_fall, cs_rise, sclk_rise;

  rx_state_t             state_q, state_d;
  logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0]     sh_q, sh_d;
  logic                  dc_q, dc_d;
  logic                  push_q, push_d;
  logic                  ferr_d;

  logic                  fifo_in_rdy, fifo_full, fifo_empty;
  logic [BYTE_W:0]       fifo_head;

  // Metastability chains; bit 0 samples the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= {SYNC_STAGES{CS_IDLE}};
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      sdin_sync <= {SYNC_STAGES{SDIN_IDLE}};
      dc_sync   <= {SYNC_STAGES{DC_IDLE}};
      cs_prev   <= CS_IDLE;
      sclk_prev <= SCLK_IDLE;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev && !cs_s;
  assign cs_rise   = !cs_prev && cs_s;
  assign sclk_rise = !sclk_prev && sclk_s;
  assign busy      = !cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      dc_q      <= DC_IDLE;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      dc_q      <= dc_d;
      push_q    <= push_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dc_d    = dc_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // CS release wins over a coincident SCLK edge.
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          sh_d  = {sh_q[BYTE_W-2:0], sdin_s};
          cnt_d = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            push_d = 1'b1;
            dc_d   = dc_s;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sh_q/dc_q are stable for the push cycle: the next SCLK rise is at least
  // two full SCLK phases away.
  oled_rx_fifo #(
    .WIDTH (BYTE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (push_q),
    .in_rdy  (fifo_in_rdy),
    .in_dat  ({dc_q, sh_q}),
    .out_vld (rx.valid),
    .out_rdy (rx.ready),
    .out_dat (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Memory is not reset, so the head is forced to zero whenever nothing is queued.
  assign rx.byte_dat = fifo_empty ? '0 : fifo_head[BYTE_W-1:0];
  assign rx.byte_dc  = fifo_empty ? 1'b0 : fifo_head[BYTE_W];

  // Drop only when full and the head is not leaving this same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push_q && fifo_full && !fifo_in_rdy) begin
      ovf <= 1'b1;
    end
  end

`ifdef OLED_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt  <= '0;
      data_cnt <= '0;
    end else if (push_q && fifo_in_rdy) begin
      if (dc_q) begin
        if (data_cnt != 16'hFFFF) data_cnt <= data_cnt + 16'd1;
      end else begin
        if (cmd_cnt != 16'hFFFF) cmd_cnt <= cmd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: directed scenarios plus randomized SPI frames
// checked against a queue-based model of the received byte stream.
module tb_oled_spi_rx;

  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n, cs, sclk, sdin, dc;
  logic ovf, frame_err, busy;
`ifdef OLED_RX_STATS_EN
  logic [15:0] cmd_cnt, data_cnt;
  int cmd_exp, data_exp;
`endif

  always #5 clk = ~clk;

  oled_spi_rx_if rx_if ();

  oled_spi_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .sclk      (sclk),
    .sdin      (sdin),
    .dc        (dc),
    .rx        (rx_if),
    .ovf       (ovf),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef OLED_RX_STATS_EN
    ,
    .cmd_cnt   (cmd_cnt),
    .data_cnt  (data_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  bit ovf_exp = 1'b0;
  int ferr_cnt = 0;
  int cons_mode = 0;   // 0: ready low, 1: ready high, 2: random
  int half = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic d, input logic [7:0] b, input bit cap);
    if (cap && exp_q.size() >= FIFO_DEPTH) begin
      ovf_exp = 1'b1;
    end else begin
      exp_q.push_back({d, b});
`ifdef OLED_RX_STATS_EN
      if (d) data_exp++; else cmd_exp++;
`endif
    end
  endtask

  // mode 1: measure VALID latency after the 8th edge (FIFO must be empty).
  // mode 2: raise READY for exactly the cycle the byte lands in the FIFO.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic d,
                           input int mode, input bit cap);
    dc = d;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      sdin = b[7-i];
      tick(half);
      sclk = 1'b1;
      if (i == 7) begin
        model_push(d, b, cap);
        if (mode == 1) begin
          int n;
          n = 0;
          do begin
            @(posedge clk);
            #1;
            n++;
          end while (!rx_if.valid && n < 12);
          check("valid_latency", n, SYNC_STAGES + 2);
          @(negedge clk);
        end else if (mode == 2) begin
          tick(SYNC_STAGES + 1);
          cons_mode = 1;
          tick(1);
          cons_mode = 0;
        end
      end
      tick(half);
    end
  endtask

  task automatic frame_open();
    cs = 1'b0;
    tick(half);
  endtask

  task automatic frame_close();
    tick(half);
    cs = 1'b1;
    tick(half + 2);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || rx_if.valid); i++) tick(1);
    check({tag, "_queue"}, exp_q.size(), 0);
    check({tag, "_valid"}, rx_if.valid, 1'b0);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    cs = 1'b1;
    sclk = 1'b1;
    sdin = 1'b0;
    dc = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
`ifdef OLED_RX_STATS_EN
    cmd_exp = 0;
    data_exp = 0;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, rx_if.valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovf"}, ovf, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_byte"}, rx_if.byte_dat, 8'h00);
    check({tag, "_byte_dc"}, rx_if.byte_dc, 1'b0);
  endtask

  // Consumer: decides READY after each falling clk edge and scores pops.
  initial begin
    rx_if.ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (cons_mode)
        0:       rx_if.ready = 1'b0;
        1:       rx_if.ready = 1'b1;
        default: rx_if.ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rst_n && rx_if.valid && rx_if.ready) begin
        if (exp_q.size() == 0) check("pop_extra", 1, 0);
        else check("pop_byte", {rx_if.byte_dc, rx_if.byte_dat}, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    rst_n = 1'b1;
    cs = 1'b1; sclk = 1'b1; sdin = 1'b0; dc = 1'b0;
    #3;
    assert_reset();
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(4);

    // Single command byte, with VALID latency measured.
    cons_mode = 1;
    f0 = ferr_cnt;
    frame_open();
    check("busy_in_frame", busy, 1'b1);
    send_bits(8'hAE, 8, 1'b0, 1, 1'b0);
    frame_close();
    wait_drain("ae");
    check("ae_no_ferr", ferr_cnt - f0, 0);

    // Back-to-back bytes in one frame.
    frame_open();
    send_bits(8'h81, 8, 1'b0, 0, 1'b0);
    send_bits(8'h7F, 8, 1'b0, 0, 1'b0);
    send_bits(8'hFF, 8, 1'b1, 0, 1'b0);
    frame_close();
    wait_drain("three");

    // Truncated byte, then a clean one.
    f0 = ferr_cnt;
    frame_open();
    send_bits(8'hA5, 5, 1'b0, 0, 1'b0);
    frame_close();
    tick(8);
    check("partial_ferr", ferr_cnt - f0, 1);
    check("partial_nopush", rx_if.valid, 1'b0);
    frame_open();
    send_bits(8'h3C, 8, 1'b0, 0, 1'b0);
    frame_close();
    wait_drain("after_partial");

    // Full FIFO with a pop landing in the same cycle as the 5th push.
    cons_mode = 0;
    frame_open();
    for (int i = 0; i < FIFO_DEPTH; i++) send_bits(8'h10 + 8'(i), 8, 1'b0, 0, 1'b0);
    send_bits(8'h10 + 8'(FIFO_DEPTH), 8, 1'b0, 2, 1'b0);
    frame_close();
    check("push_pop_full_ovf", ovf, 1'b0);
    cons_mode = 1;
    wait_drain("push_pop_full");

    // Overflow: one byte more than the FIFO holds, consumer stalled.
    cons_mode = 0;
    frame_open();
    for (int i = 0; i <= FIFO_DEPTH; i++) send_bits(8'(i), 8, 1'b0, 0, 1'b1);
    frame_close();
    tick(10);
    check("ovf_set", ovf, ovf_exp);
    check("ovf_head_hold", {rx_if.valid, rx_if.byte_dc, rx_if.byte_dat}, {1'b1, 1'b0, 8'h00});
    cons_mode = 1;
    wait_drain("ovf");
    check("ovf_sticky", ovf, 1'b1);

    // Reset mid-byte with data queued.
    cons_mode = 0;
    frame_open();
    send_bits(8'h99, 8, 1'b1, 0, 1'b0);
    send_bits(8'hFF, 3, 1'b0, 0, 1'b0);
    check("pre_reset_valid", rx_if.valid, 1'b1);
    #2;
    assert_reset();
    #1;
    check_reset_outputs("midbyte_reset");
    tick(3);
    rst_n = 1'b1;
    tick(4);
    cons_mode = 1;
    frame_open();
    send_bits(8'h55, 8, 1'b1, 0, 1'b0);
    frame_close();
    wait_drain("post_reset");

    // Random frames, some ending in a truncated byte, random READY.
    cons_mode = 2;
    begin
      int ferr_exp;
      ferr_exp = 0;
      f0 = ferr_cnt;
      for (int f = 0; f < 10; f++) begin
        half = $urandom_range(SYNC_STAGES + 1, SYNC_STAGES + 3);
        frame_open();
        for (int k = 0, nb = $urandom_range(1, 4); k < nb; k++)
          send_bits(8'($urandom), 8, 1'($urandom_range(0, 1)), 0, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          send_bits(8'($urandom), $urandom_range(1, 7), 1'b0, 0, 1'b0);
          ferr_exp++;
        end
        frame_close();
      end
      wait_drain("random");
      check("random_ferr", ferr_cnt - f0, ferr_exp);
      check("random_ovf", ovf, 1'b0);
    end
`ifdef OLED_RX_STATS_EN
    check("cmd_cnt", cmd_cnt, cmd_exp);
    check("data_cnt", data_cnt, data_exp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
